// File: rtl/fpu_issue_unit.sv
// Issue/writeback front end for the combinational FPU: owns the FP register file, issues one command at a time, returns results.
// Optional: define FPU_ISSUE_ILLEGAL_EN to flag opcode 3'b111 as illegal (no writeback, resp_err_o=1).
module fpu_issue_unit #(
   parameter  int WIDTH = 32,
   parameter  int REGS  = 8,
   localparam int RA_W  = $clog2(REGS)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [2:0]       cmd_op_i,
   input  logic [RA_W-1:0]  cmd_rd_i,
   input  logic [RA_W-1:0]  cmd_rs1_i,
   input  logic [RA_W-1:0]  cmd_rs2_i,
   input  logic             ld_en_i,
   input  logic [RA_W-1:0]  ld_addr_i,
   input  logic [WIDTH-1:0] ld_data_i,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic [WIDTH-1:0] resp_data_o,
   output logic [RA_W-1:0]  resp_rd_o,
   output logic             resp_err_o,
   output logic             busy_o,
   output logic [WIDTH-1:0] fpu_a_o,
   output logic [WIDTH-1:0] fpu_b_o,
   output logic [2:0]       fpu_ctrl_o,
   input  logic [WIDTH-1:0] fpu_result_i
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_rf [REGS];
   logic [RA_W-1:0]  r_rd;
   logic             r_cmd_ready;
   logic             r_resp_valid;
   logic [WIDTH-1:0] r_resp_data;
   logic [RA_W-1:0]  r_resp_rd;
   logic             r_busy;
   logic [WIDTH-1:0] r_fpu_a;
   logic [WIDTH-1:0] r_fpu_b;
   logic [2:0]       r_fpu_ctrl;
`ifdef FPU_ISSUE_ILLEGAL_EN
   logic             r_illegal;
   logic             r_resp_err;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= S_IDLE;
         r_rd         <= '0;
         r_cmd_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_data  <= '0;
         r_resp_rd    <= '0;
         r_busy       <= 1'b0;
         r_fpu_a      <= '0;
         r_fpu_b      <= '0;
         r_fpu_ctrl   <= '0;
`ifdef FPU_ISSUE_ILLEGAL_EN
         r_illegal    <= 1'b0;
         r_resp_err   <= 1'b0;
`endif
         for (int i = 0; i < REGS; i++) r_rf[i] <= '0;
      end else begin
         // Load first so that a same-cycle writeback to the same entry overrides it.
         if (ld_en_i) r_rf[ld_addr_i] <= ld_data_i;
         case (r_state)
            S_IDLE: begin
               if (cmd_valid_i && r_cmd_ready) begin
                  r_rd        <= cmd_rd_i;
                  r_fpu_a     <= r_rf[cmd_rs1_i];
                  r_fpu_b     <= r_rf[cmd_rs2_i];
                  r_fpu_ctrl  <= cmd_op_i;
                  r_cmd_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= S_EXEC;
`ifdef FPU_ISSUE_ILLEGAL_EN
                  r_illegal   <= (cmd_op_i == 3'b111);
`endif
               end
            end
            S_EXEC: begin
`ifdef FPU_ISSUE_ILLEGAL_EN
               if (r_illegal) begin
                  r_resp_data <= '0;
                  r_resp_err  <= 1'b1;
               end else begin
                  r_rf[r_rd]  <= fpu_result_i;
                  r_resp_data <= fpu_result_i;
                  r_resp_err  <= 1'b0;
               end
`else
               r_rf[r_rd]   <= fpu_result_i;
               r_resp_data  <= fpu_result_i;
`endif
               r_resp_rd    <= r_rd;
               r_resp_valid <= 1'b1;
               r_state      <= S_RESP;
            end
            S_RESP: begin
               if (resp_ready_i) begin
                  r_resp_valid <= 1'b0;
                  r_busy       <= 1'b0;
                  r_cmd_ready  <= 1'b1;
                  r_state      <= S_IDLE;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_cmd_ready <= 1'b1;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready_o  = r_cmd_ready;
   assign resp_valid_o = r_resp_valid;
   assign resp_data_o  = r_resp_data;
   assign resp_rd_o    = r_resp_rd;
   assign busy_o       = r_busy;
   assign fpu_a_o      = r_fpu_a;
   assign fpu_b_o      = r_fpu_b;
   assign fpu_ctrl_o   = r_fpu_ctrl;
`ifdef FPU_ISSUE_ILLEGAL_EN
   assign resp_err_o   = r_resp_err;
`else
   assign resp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_issue_unit.sv
// Bench for fpu_issue_unit: stand-in FPU, table vectors, corner-case sequences and a randomized transaction-level model.
module tb_fpu_issue_unit;

   logic        clk;
   logic        rst_i;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic [2:0]  cmd_op_i;
   logic [2:0]  cmd_rd_i;
   logic [2:0]  cmd_rs1_i;
   logic [2:0]  cmd_rs2_i;
   logic        ld_en_i;
   logic [2:0]  ld_addr_i;
   logic [31:0] ld_data_i;
   logic        resp_valid_o;
   logic        resp_ready_i;
   logic [31:0] resp_data_o;
   logic [2:0]  resp_rd_o;
   logic        resp_err_o;
   logic        busy_o;
   logic [31:0] fpu_a_o;
   logic [31:0] fpu_b_o;
   logic [2:0]  fpu_ctrl_o;
   logic [31:0] fpu_result_i;

   int n_chk = 0;
   int n_err = 0;
   logic [31:0] m_rf [8];

   fpu_issue_unit #(.WIDTH(32), .REGS(8)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
      .cmd_rd_i(cmd_rd_i), .cmd_rs1_i(cmd_rs1_i), .cmd_rs2_i(cmd_rs2_i),
      .ld_en_i(ld_en_i), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
      .resp_data_o(resp_data_o), .resp_rd_o(resp_rd_o), .resp_err_o(resp_err_o),
      .busy_o(busy_o), .fpu_a_o(fpu_a_o), .fpu_b_o(fpu_b_o), .fpu_ctrl_o(fpu_ctrl_o),
      .fpu_result_i(fpu_result_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single <-> double conversion for normal numbers only; enough for a stand-in FPU.
   function automatic real sp2r(input logic [31:0] x);
      if (x[30:23] == 8'd0) return 0.0;
      return $bitstoreal({x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'd0});
   endfunction

   function automatic logic [31:0] r2sp(input real r);
      logic [63:0] d;
      logic [10:0] e;
      d = $realtobits(r);
      if (d[62:52] == 11'd0) return 32'd0;
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      case (op)
         3'b000:  return r2sp(sp2r(a) + sp2r(b));
         3'b001:  return r2sp(sp2r(a) - sp2r(b));
         3'b010:  return r2sp(sp2r(a) * sp2r(b));
         3'b011:  return a;
         3'b100:  return b;
         3'b101:  return {1'b0, a[30:0]};
         3'b110:  return {~a[31], a[30:0]};
         default: return 32'd0;
      endcase
   endfunction

   assign fpu_result_i = fpu_model(fpu_a_o, fpu_b_o, fpu_ctrl_o);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rnd_fp();
      logic       s;
      logic [7:0] e;
      logic [22:0] m;
      s = 1'($urandom_range(0, 1));
      e = 8'($urandom_range(120, 134));
      m = 23'($urandom);
      return {s, e, m};
   endfunction

   task automatic ld_reg(input logic [2:0] a, input logic [31:0] d);
      ld_en_i = 1'b1; ld_addr_i = a; ld_data_i = d;
      @(posedge clk); #1;
      ld_en_i = 1'b0;
      m_rf[a] = d;
   endtask

   // One full command transaction; always entered and left at posedge+1 with the DUT idle.
   task automatic run_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
                          input bit ld_acc, input logic [2:0] la_addr, input logic [31:0] la_data,
                          input bit ld_ex, input logic [2:0] le_addr, input logic [31:0] le_data,
                          input int hold, output logic [31:0] got);
      logic [31:0] ea, eb, er;
      logic        eerr;
      ea = m_rf[rs1];
      eb = m_rf[rs2];
      er = fpu_model(ea, eb, op);
      eerr = 1'b0;
`ifdef FPU_ISSUE_ILLEGAL_EN
      if (op == 3'b111) begin er = 32'd0; eerr = 1'b1; end
`endif
      chk("cmd_ready_idle", 32'(cmd_ready_o), 32'd1);
      cmd_valid_i = 1'b1; cmd_op_i = op; cmd_rd_i = rd; cmd_rs1_i = rs1; cmd_rs2_i = rs2;
      ld_en_i = ld_acc; ld_addr_i = la_addr; ld_data_i = la_data;
      @(posedge clk); #1;
      cmd_valid_i = 1'b0;
      if (ld_acc) m_rf[la_addr] = la_data;
      ld_en_i = ld_ex; ld_addr_i = le_addr; ld_data_i = le_data;
      chk("exec_fpu_a", fpu_a_o, ea);
      chk("exec_fpu_b", fpu_b_o, eb);
      chk("exec_fpu_ctrl", 32'(fpu_ctrl_o), 32'(op));
      chk("exec_resp_valid", 32'(resp_valid_o), 32'd0);
      chk("exec_busy", 32'(busy_o), 32'd1);
      chk("exec_cmd_ready", 32'(cmd_ready_o), 32'd0);
      @(posedge clk); #1;
      ld_en_i = 1'b0;
      if (ld_ex) m_rf[le_addr] = le_data;
      if (!eerr) m_rf[rd] = er;
      chk("resp_valid_lat2", 32'(resp_valid_o), 32'd1);
      chk("resp_data", resp_data_o, er);
      chk("resp_rd", 32'(resp_rd_o), 32'(rd));
      chk("resp_err", 32'(resp_err_o), 32'(eerr));
      got = resp_data_o;
      for (int h = 0; h < hold; h++) begin
         cmd_valid_i = 1'b1; cmd_op_i = ~op; cmd_rs1_i = ~rs1;
         @(posedge clk); #1;
         chk("hold_resp_valid", 32'(resp_valid_o), 32'd1);
         chk("hold_resp_data", resp_data_o, er);
         chk("hold_resp_rd", 32'(resp_rd_o), 32'(rd));
         chk("hold_cmd_ready", 32'(cmd_ready_o), 32'd0);
         chk("hold_fpu_ctrl", 32'(fpu_ctrl_o), 32'(op));
      end
      cmd_valid_i = 1'b0;
      resp_ready_i = 1'b1;
      @(posedge clk); #1;
      resp_ready_i = 1'b0;
      chk("post_resp_valid", 32'(resp_valid_o), 32'd0);
      chk("post_cmd_ready", 32'(cmd_ready_o), 32'd1);
      chk("post_busy", 32'(busy_o), 32'd0);
      chk("post_fpu_a_hold", fpu_a_o, ea);
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [2:0]  rd;
      logic [2:0]  rs1;
      logic [2:0]  rs2;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [4];

   initial begin
      logic [31:0] got;
      tbl[0] = '{op: 3'b010, rd: 3'd3, rs1: 3'd1, rs2: 3'd2, exp: 32'h40C00000};
      tbl[1] = '{op: 3'b000, rd: 3'd4, rs1: 3'd3, rs2: 3'd1, exp: 32'h41000000};
      tbl[2] = '{op: 3'b101, rd: 3'd5, rs1: 3'd5, rs2: 3'd0, exp: 32'h40000000};
      tbl[3] = '{op: 3'b110, rd: 3'd6, rs1: 3'd5, rs2: 3'd0, exp: 32'hC0000000};

      rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_rd_i = '0; cmd_rs1_i = '0; cmd_rs2_i = '0;
      ld_en_i = 1'b0; ld_addr_i = '0; ld_data_i = '0; resp_ready_i = 1'b0;
      for (int i = 0; i < 8; i++) m_rf[i] = 32'd0;
      repeat (2) @(posedge clk);
      #1 rst_i = 1'b0;
      chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_resp_data", resp_data_o, 32'd0);
      chk("rst_fpu_a", fpu_a_o, 32'd0);
      chk("rst_fpu_ctrl", 32'(fpu_ctrl_o), 32'd0);

      // Table vectors: multiply, add, abs with rd==rs1, negate of the updated register.
      ld_reg(3'd1, 32'h40000000);
      ld_reg(3'd2, 32'h40400000);
      ld_reg(3'd5, 32'hC0000000);
      for (int i = 0; i < 4; i++) begin
         run_cmd(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, 1'b0, '0, '0, 1'b0, '0, '0, 0, got);
         chk("tbl_result", got, tbl[i].exp);
      end

      // Response held off 5 cycles while a second command is offered.
      run_cmd(3'b011, 3'd7, 3'd1, 3'd2, 1'b0, '0, '0, 1'b0, '0, '0, 5, got);

      // Load to rs1 on accept is not seen; load to rd during EXEC loses to writeback.
      run_cmd(3'b000, 3'd2, 3'd1, 3'd2, 1'b1, 3'd1, 32'h3F800000, 1'b1, 3'd2, 32'h12345678, 0, got);
      run_cmd(3'b100, 3'd0, 3'd2, 3'd1, 1'b0, '0, '0, 1'b0, '0, '0, 0, got);
      chk("ld_rd_lost_to_wb", fpu_a_o, 32'h40A00000);
      chk("ld_rs1_visible_later", fpu_b_o, 32'h3F800000);

      // Illegal opcode handling.
      run_cmd(3'b111, 3'd3, 3'd1, 3'd2, 1'b0, '0, '0, 1'b0, '0, '0, 0, got);
      run_cmd(3'b011, 3'd6, 3'd3, 3'd3, 1'b0, '0, '0, 1'b0, '0, '0, 0, got);
`ifdef FPU_ISSUE_ILLEGAL_EN
      chk("illegal_rf_kept", fpu_a_o, 32'h40C00000);
`else
      chk("op7_rf_zeroed", fpu_a_o, 32'd0);
`endif

      // Reset during EXEC aborts the command and clears the register file.
      cmd_valid_i = 1'b1; cmd_op_i = 3'b010; cmd_rd_i = 3'd4; cmd_rs1_i = 3'd1; cmd_rs2_i = 3'd2;
      @(posedge clk); #1;
      cmd_valid_i = 1'b0;
      chk("pre_rst_busy", 32'(busy_o), 32'd1);
      rst_i = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0;
      for (int i = 0; i < 8; i++) m_rf[i] = 32'd0;
      chk("midrst_resp_valid", 32'(resp_valid_o), 32'd0);
      chk("midrst_cmd_ready", 32'(cmd_ready_o), 32'd1);
      chk("midrst_busy", 32'(busy_o), 32'd0);
      chk("midrst_fpu_a", fpu_a_o, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("midrst_no_resp", 32'(resp_valid_o), 32'd0);
      for (int i = 0; i < 8; i += 2)
         run_cmd(3'b011, 3'(i), 3'(i), 3'(i + 1), 1'b0, '0, '0, 1'b0, '0, '0, 0, got);

      // Randomized transactions against the register-file model.
      for (int it = 0; it < 40; it++) begin
         ld_reg(3'($urandom_range(0, 7)), rnd_fp());
         ld_reg(3'($urandom_range(0, 7)), rnd_fp());
         run_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rnd_fp(),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rnd_fp(),
                 int'($urandom_range(0, 2)), got);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
